enemy_wave_ctrl: RTL and testbench
==================================

# enemy_wave_ctrl

Parametrised enemy-plane field controller: owns N_SLOTS independent enemy slots, each with its own X/Y position, lifecycle state and respawn. It spawns planes at pseudo-random X positions, advances them down the screen on a divided move tick, and retires them on hit or escape. It tracks lives and kills and freezes the field on game over. It sits between the game-logic/collision block (which supplies `hit`) and the VGA draw/erase sequencer (which consumes `x_flat`, `y_flat` and `active`).

## Interface
- `N_SLOTS`, 10: number of enemy slots (1..16).
- `X_W`, 8: X coordinate width.
- `Y_W`, 8: Y coordinate width.
- `X_LIMIT`, 152: maximum spawn X. Must satisfy X_LIMIT ≥ 2^(X_W-1)-1.
- `Y_MAX`, 120: Y value at which a plane escapes.
- `TICK_DIV`, 12500000: clocks per move tick (1/4 s at 50 MHz). Must be ≥ 2.
- `LIVES`, 3: escapes allowed before game over (1..15).
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be nonzero.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `move_en`  in  1  enables the tick divider.
- `restart`  in  1  single-cycle pulse; re-arms the field after game over.
- `plane_amount`  in  5  number of enabled slots; values above N_SLOTS are clamped.
- `flying_rate`  in  2  Y pixels advanced per tick.
- `hit`  in  N_SLOTS  per-slot destroy pulse from collision logic.
- `x_flat`  out  N_SLOTS*X_W  slot i is at [i*X_W +: X_W].
- `y_flat`  out  N_SLOTS*Y_W  slot i is at [i*Y_W +: Y_W].
- `active`  out  N_SLOTS  slot is in FLY (drawable).
- `tick`  out  1  single-cycle move-tick pulse.
- `escaped`  out  1  single-cycle pulse when any plane escaped on this tick.
- `lives`  out  4  remaining lives.
- `kills`  out  8  hits counted, saturating at 255.
- `game_over`  out  1  the field is frozen.

## Operation
- **Slot enable:** slot i is enabled iff i < min(plane_amount, N_SLOTS).
- **Per-slot state:** IDLE, PENDING, FLY.
  - IDLE → PENDING when the slot is enabled.
  - Any state → IDLE on the cycle after the slot is disabled. On that transition, y = 0 and active = 0.
  - PENDING → FLY on a spawn grant. On the grant, x = spawn value and y = 0.
  - FLY → PENDING on a hit or an escape. On the transition, y = 0; x holds its value.
- **Tick divider:**
  - The counter runs 0..TICK_DIV-1 while move_en = 1 and holds while move_en = 0.
  - `tick` = 1 when the counter equals TICK_DIV-1 and move_en = 1.
  - The divider holds while game_over = 1.
- **Movement (on tick):** for each FLY slot, compute sum = y + flying_rate at Y_W+1 bits.
  - If sum ≥ Y_MAX, the plane escapes: the slot goes to PENDING and y = 0.
  - Otherwise y = sum.
  - flying_rate = 0 means no motion.
- **Spawn (on tick):** the lowest-index slot that was already PENDING before this tick is granted. At most one grant per tick.
  - Slots that entered PENDING on this same tick are not eligible until the next tick.
- **Spawn X:** a 16-bit Galois LFSR with taps 16'hB400 (shift right; if the old bit0 = 1, XOR with 16'hB400) advances only on a grant.
  - Let r = the advanced LFSR value [X_W-1:0].
  - x = r if r ≤ X_LIMIT, else r - X_LIMIT - 1.
- **Hit:**
  - hit[i] with slot i in FLY retires the plane at once, regardless of tick, and increments kills (saturating).
  - hit[i] on a non-FLY slot is ignored.
  - If a hit and an escape fall on the same cycle for the same slot, the hit wins: kills increments, lives does not change.
- **Escape:**
  - Each tick with one or more escapes decrements lives by 1, not by the escape count. This is decided behaviour.
  - `escaped` pulses on that tick.
  - When lives reaches 0, game_over is set on the same edge.
- **Game over:**
  - Positions freeze: no movement, no spawns, hits ignored.
  - `active` holds its current value so the last frame remains drawable.
- **Restart:** a restart pulse (any time) does the following:
  - all enabled slots go to PENDING, with y = 0 and active = 0;
  - lives = LIVES, kills = 0, game_over = 0;
  - the tick counter is cleared;
  - the LFSR is not reseeded.
- **Priority:** reset > restart > hit > tick actions.

## Timing
- Reset values:
  - all slots IDLE, x = 0, y = 0, active = 0;
  - tick = 0, escaped = 0;
  - lives = LIVES, kills = 0, game_over = 0;
  - tick counter = 0, LFSR = LFSR_SEED.
- Enabled slots reach PENDING on the first clock edge after reset is released.
- All outputs are registered and change one clock after the causing tick, hit, restart or plane_amount edge.
- `tick` and `escaped` are high for exactly one cycle.
- The first tick occurs TICK_DIV cycles after move_en rises from a cleared counter.
- When reset is asserted mid-operation, all state clears immediately (asynchronously) with no partial update.

## Test plan
Bench configuration: N_SLOTS=4, TICK_DIV=4, Y_MAX=8, LIVES=2, plane_amount=2, flying_rate=2, move_en=1.
- **Spawn sequence:** reset released → tick 1 grants slot 0 with x=112, tick 2 grants slot 1 with x=56. active=4'b0011 after tick 2.
- **Movement and escape:** slot 0 y goes 0,2,4,6. On the tick where y+2=8, slot 0 goes to PENDING with y=0, escaped pulses, lives goes 2→1, and slot 0 is re-granted on the following tick, not the same one.
- **Hit handling:** hit=4'b0010 while slot 1 is in FLY → active[1]=0 and kills=1 next cycle. hit=4'b0100 (slot IDLE) → no change.
- **Same-slot hit/escape:** hit[0] asserted on the same cycle slot 0 escapes → kills increments, lives unchanged, escaped=0.
- **Game over and restart:** two escape ticks → lives=0, game_over=1; y frozen through 20 further cycles. Then restart → game_over=0, lives=2, active=0, and spawning resumes on the next tick.
- **Disable mid-flight:** plane_amount 2→1 mid-flight → slot 1 goes IDLE with y=0 next cycle. Then plane_amount=9 → clamped to 4, slots 1-3 go PENDING.

Source files
------------

// File: rtl/enemy_wave_ctrl.sv
// Enemy-plane field controller: N_SLOTS slots that spawn at LFSR-chosen X,
// fall one step per divided move tick, retire on hit/escape; tracks lives/kills.
// Ports: clk, reset (async, active-high), move_en, restart, plane_amount,
//        flying_rate, hit[N_SLOTS] in; x_flat, y_flat, active, tick, escaped,
//        lives, kills, game_over out (all registered).
module enemy_wave_ctrl #(
    parameter int          N_SLOTS   = 10,
    parameter int          X_W       = 8,
    parameter int          Y_W       = 8,
    parameter int          X_LIMIT   = 152,
    parameter int          Y_MAX     = 120,
    parameter int          TICK_DIV  = 12500000,
    parameter int          LIVES     = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   move_en,
    input  logic                   restart,
    input  logic [4:0]             plane_amount,
    input  logic [1:0]             flying_rate,
    input  logic [N_SLOTS-1:0]     hit,
    output logic [N_SLOTS*X_W-1:0] x_flat,
    output logic [N_SLOTS*Y_W-1:0] y_flat,
    output logic [N_SLOTS-1:0]     active,
    output logic                   tick,
    output logic                   escaped,
    output logic [3:0]             lives,
    output logic [7:0]             kills,
    output logic                   game_over
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FLY     = 2'd2
    } slot_t;

    localparam int             CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_TOP = CW'(TICK_DIV - 1);
    localparam logic [X_W:0]   XL      = (X_W+1)'(X_LIMIT);
    localparam logic [X_W-1:0] XL_LO   = X_W'(X_LIMIT);
    localparam logic [Y_W:0]   YM      = (Y_W+1)'(Y_MAX);

    slot_t          st_q [N_SLOTS];
    slot_t          st_d [N_SLOTS];
    logic [X_W-1:0] x_q  [N_SLOTS];
    logic [X_W-1:0] x_d  [N_SLOTS];
    logic [Y_W-1:0] y_q  [N_SLOTS];
    logic [Y_W-1:0] y_d  [N_SLOTS];

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d, lfsr_adv;
    logic [3:0]         lives_d;
    logic [7:0]         kills_d;
    logic               go_d, tick_d, esc_d;
    logic [4:0]         n_en;
    logic [N_SLOTS-1:0] en, gnt;
    logic               taken, run, tick_now, any_esc;
    logic [X_W-1:0]     r, spawn_x;
    logic [Y_W:0]       sum;

    assign n_en     = (plane_amount > 5'(N_SLOTS)) ? 5'(N_SLOTS) : plane_amount;
    assign run      = move_en & ~game_over;
    assign tick_now = run & (cnt_q == CNT_TOP);

    // Galois step; the LFSR only commits this value when a grant happens.
    assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign r        = lfsr_adv[X_W-1:0];
    assign spawn_x  = ({1'b0, r} <= XL) ? r : r - XL_LO - X_W'(1);

    // Grant candidate: lowest enabled slot already PENDING before this edge.
    always_comb begin
        en    = '0;
        gnt   = '0;
        taken = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            en[i] = (5'(i) < n_en);
            if (!taken && en[i] && st_q[i] == PENDING) begin
                gnt[i] = 1'b1;
                taken  = 1'b1;
            end
        end
    end

    always_comb begin
        st_d    = st_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        lives_d = lives;
        kills_d = kills;
        go_d    = game_over;
        tick_d  = 1'b0;
        esc_d   = 1'b0;
        any_esc = 1'b0;
        sum     = '0;
        if (restart) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                st_d[i] = en[i] ? PENDING : IDLE;
                y_d[i]  = '0;
            end
            cnt_d   = '0;
            lives_d = 4'(LIVES);
            kills_d = '0;
            go_d    = 1'b0;
        end else begin
            if (run)
                cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + CW'(1);
            tick_d = tick_now;
            for (int i = 0; i < N_SLOTS; i++) begin
                if (!en[i]) begin
                    st_d[i] = IDLE;
                    y_d[i]  = '0;
                end else begin
                    unique case (st_q[i])
                        IDLE: st_d[i] = PENDING;
                        PENDING: begin
                            if (tick_now && gnt[i]) begin
                                st_d[i] = FLY;
                                x_d[i]  = spawn_x;
                                y_d[i]  = '0;
                                lfsr_d  = lfsr_adv;
                            end
                        end
                        FLY: begin
                            // Frozen field: no hits, no motion.
                            if (!game_over) begin
                                if (hit[i]) begin
                                    st_d[i] = PENDING;
                                    y_d[i]  = '0;
                                    if (kills_d != 8'hFF)
                                        kills_d = kills_d + 8'd1;
                                end else if (tick_now) begin
                                    sum = {1'b0, y_q[i]}
                                        + {{(Y_W-1){1'b0}}, flying_rate};
                                    if (sum >= YM) begin
                                        st_d[i] = PENDING;
                                        y_d[i]  = '0;
                                        any_esc = 1'b1;
                                    end else begin
                                        y_d[i] = sum[Y_W-1:0];
                                    end
                                end
                            end
                        end
                        default: st_d[i] = IDLE;
                    endcase
                end
            end
            // One life per tick, however many planes got through.
            if (any_esc) begin
                esc_d = 1'b1;
                if (lives != 4'd0)
                    lives_d = lives - 4'd1;
                if (lives <= 4'd1)
                    go_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                st_q[i] <= IDLE;
                x_q[i]  <= '0;
                y_q[i]  <= '0;
            end
            cnt_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            lives     <= 4'(LIVES);
            kills     <= '0;
            game_over <= 1'b0;
            tick      <= 1'b0;
            escaped   <= 1'b0;
        end else begin
            st_q      <= st_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            lives     <= lives_d;
            kills     <= kills_d;
            game_over <= go_d;
            tick      <= tick_d;
            escaped   <= esc_d;
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
        assign x_flat[g*X_W +: X_W] = x_q[g];
        assign y_flat[g*Y_W +: Y_W] = y_q[g];
        assign active[g]            = (st_q[g] == FLY);
    end

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Bench for enemy_wave_ctrl: reference model feeds a scoreboard queue,
// plus directed checks of the spawn/escape/hit/game-over story.
module tb_enemy_wave_ctrl;

    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            move_en = 1'b1;
    logic            restart = 1'b0;
    logic [4:0]      plane_amount = 5'd2;
    logic [1:0]      flying_rate = 2'd2;
    logic [NS-1:0]   hit = '0;
    logic [NS*8-1:0] x_flat;
    logic [NS*8-1:0] y_flat;
    logic [NS-1:0]   active;
    logic            tick, escaped, game_over;
    logic [3:0]      lives;
    logic [7:0]      kills;

    enemy_wave_ctrl #(
        .N_SLOTS(NS), .X_W(8), .Y_W(8), .X_LIMIT(152), .Y_MAX(8),
        .TICK_DIV(4), .LIVES(2), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .move_en(move_en), .restart(restart),
        .plane_amount(plane_amount), .flying_rate(flying_rate), .hit(hit),
        .x_flat(x_flat), .y_flat(y_flat), .active(active), .tick(tick),
        .escaped(escaped), .lives(lives), .kills(kills),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  act;
        logic [31:0] x;
        logic [31:0] y;
        logic        tk;
        logic        esc;
        logic [3:0]  lv;
        logic [7:0]  kl;
        logic        go;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: 0 idle, 1 pending, 2 flying
    int          m_st[NS];
    int          m_x[NS];
    int          m_y[NS];
    int          m_cnt, m_lives, m_kills;
    bit          m_go, m_tick, m_esc;
    logic [15:0] m_lfsr;

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_st[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cnt = 0; m_lives = 2; m_kills = 0;
        m_go = 0; m_tick = 0; m_esc = 0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        int n, g, s, rv;
        bit tk, e;
        n = (int'(plane_amount) > NS) ? NS : int'(plane_amount);
        if (restart) begin
            for (int i = 0; i < NS; i++) begin
                m_st[i] = (i < n) ? 1 : 0;
                m_y[i] = 0;
            end
            m_cnt = 0; m_lives = 2; m_kills = 0;
            m_go = 0; m_tick = 0; m_esc = 0;
            return;
        end
        tk = move_en && !m_go && m_cnt == 3;
        if (move_en && !m_go) m_cnt = (m_cnt + 1) % 4;
        g = -1;
        if (tk)
            for (int i = 0; i < NS; i++)
                if (g < 0 && i < n && m_st[i] == 1) g = i;
        e = 0;
        for (int i = 0; i < NS; i++) begin
            if (i >= n) begin
                m_st[i] = 0; m_y[i] = 0;
            end else if (m_st[i] == 0) begin
                m_st[i] = 1;
            end else if (m_st[i] == 1) begin
                if (i == g) begin
                    if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
                    else m_lfsr = m_lfsr >> 1;
                    rv = int'(m_lfsr[7:0]);
                    m_x[i] = (rv <= 152) ? rv : rv - 153;
                    m_y[i] = 0; m_st[i] = 2;
                end
            end else if (!m_go) begin
                if (hit[i]) begin
                    m_st[i] = 1; m_y[i] = 0;
                    if (m_kills < 255) m_kills++;
                end else if (tk) begin
                    s = m_y[i] + int'(flying_rate);
                    if (s >= 8) begin
                        m_st[i] = 1; m_y[i] = 0; e = 1;
                    end else m_y[i] = s;
                end
            end
        end
        if (e) begin
            if (m_lives > 0) m_lives--;
            if (m_lives == 0) m_go = 1;
        end
        m_tick = tk; m_esc = e;
    endtask

    function automatic exp_t m_pack();
        exp_t r;
        r = '0;
        for (int i = 0; i < NS; i++) begin
            r.act[i]      = (m_st[i] == 2);
            r.x[i*8 +: 8] = m_x[i][7:0];
            r.y[i*8 +: 8] = m_y[i][7:0];
        end
        r.tk = m_tick; r.esc = m_esc;
        r.lv = m_lives[3:0]; r.kl = m_kills[7:0]; r.go = m_go;
        return r;
    endfunction

    task automatic step();
        exp_t e;
        model_step();
        sb.push_back(m_pack());
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("sb_active", active, e.act);
        check("sb_x", x_flat, e.x);
        check("sb_y", y_flat, e.y);
        check("sb_tick", tick, e.tk);
        check("sb_escaped", escaped, e.esc);
        check("sb_lives", lives, e.lv);
        check("sb_kills", kills, e.kl);
        check("sb_game_over", game_over, e.go);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_active", active, 0);
        check("rst_lives", lives, 2);
        check("rst_kills", kills, 0);
        check("rst_go", game_over, 0);
        check("rst_tick", tick, 0);
        check("rst_x", x_flat, 0);
        check("rst_y", y_flat, 0);
        @(negedge clk);
        reset = 1'b0;
        m_reset();

        repeat (4) step();
        check("spawn0_x", x_flat[7:0], 112);
        check("spawn0_act", active, 4'b0001);
        check("spawn0_tick", tick, 1);
        repeat (4) step();
        check("spawn1_x", x_flat[15:8], 56);
        check("spawn1_act", active, 4'b0011);
        step();
        hit = 4'b0010; step(); hit = '0;
        check("hit1_act", active, 4'b0001);
        check("hit1_kills", kills, 1);
        hit = 4'b0100; step(); hit = '0;
        check("hit_idle_kills", kills, 1);
        check("hit_idle_act", active, 4'b0001);
        step();
        check("respawn1_x", x_flat[15:8], 3);
        check("respawn1_act", active, 4'b0011);
        repeat (7) step();
        hit = 4'b0001; step(); hit = '0;
        check("hitesc_kills", kills, 2);
        check("hitesc_lives", lives, 2);
        check("hitesc_esc", escaped, 0);
        check("hitesc_act", active, 4'b0010);
        repeat (8) step();
        check("esc_pulse", escaped, 1);
        check("esc_lives", lives, 1);
        step();
        check("esc_one_cycle", escaped, 0);
        repeat (11) step();
        check("go_set", game_over, 1);
        check("go_lives", lives, 0);
        hit = 4'b0010;
        repeat (20) step();
        hit = '0;
        check("freeze_y1", y_flat[15:8], 4);
        check("freeze_x1", x_flat[15:8], 39);
        check("freeze_act", active, 4'b0010);
        check("freeze_kills", kills, 2);
        restart = 1'b1; step(); restart = 1'b0;
        check("rs_go", game_over, 0);
        check("rs_lives", lives, 2);
        check("rs_act", active, 0);
        check("rs_kills", kills, 0);
        repeat (4) step();
        check("rs_spawn_act", active, 4'b0001);
        check("rs_spawn_x", x_flat[7:0], 19);
        repeat (9) step();
        check("dis_pre_y1", y_flat[15:8], 2);
        plane_amount = 5'd1; step();
        check("dis_act", active, 4'b0001);
        check("dis_y1", y_flat[15:8], 0);
        plane_amount = 5'd9; step();
        step();
        check("clamp_grant1", active, 4'b0011);
        repeat (4) step();
        check("same_tick_rule", active, 4'b0110);
        check("same_tick_lives", lives, 1);

        plane_amount = 5'd4; flying_rate = 2'd0;
        restart = 1'b1; step(); restart = 1'b0;
        hit = 4'hF;
        repeat (1200) step();
        hit = '0;
        check("kills_sat", kills, 255);

        for (int k = 0; k < 300; k++) begin
            plane_amount = 5'($urandom_range(0, 9));
            flying_rate  = 2'($urandom_range(0, 3));
            move_en      = ($urandom_range(0, 9) != 0);
            restart      = ($urandom_range(0, 49) == 0);
            hit          = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            step();
        end

        restart = 1'b0; hit = '0; move_en = 1'b1;
        plane_amount = 5'd2; flying_rate = 2'd2;
        #2;
        reset = 1'b1;
        #1;
        check("async_lives", lives, 2);
        check("async_kills", kills, 0);
        check("async_act", active, 0);
        check("async_go", game_over, 0);
        check("async_y", y_flat, 0);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        repeat (4) step();
        check("post_rst_x", x_flat[7:0], 112);
        check("post_rst_act", active, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
